// File: rtl/cpu_clk_pkg.sv
// Shared types and phase-decode constants for the CPU phase sequencer.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    localparam int PH_IMEM = 0;

    function automatic int ph_dmem(input int phases);
        return phases / 2;
    endfunction

    function automatic int ph_commit(input int phases);
        return phases - 1;
    endfunction

endpackage

// File: rtl/cpu_phase_counter.sv
// Mod-PHASES phase counter: clear wins over run; wrap flags the last phase.
module cpu_phase_counter #(
    parameter int PHASES = 4,
    parameter int PW     = $clog2(PHASES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          run_i,
    output logic [PW-1:0] phase_o,
    output logic          wrap_o
);

    logic [PW-1:0] phase_q, phase_d;

    assign wrap_o  = (phase_q == PW'(PHASES - 1));
    assign phase_o = phase_q;

    always_comb begin
        phase_d = phase_q;
        if (clear_i) begin
            phase_d = '0;
        end else if (run_i) begin
            phase_d = wrap_o ? '0 : phase_q + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/cpu_phase_ctrl.sv
// Phase sequencer driving one-cycle enables for imem/dmem/regfile/processor,
// with stretched core reset, halt/single-step and a processor cycle counter.
//
// state  | meaning
// HOLD   | core_reset asserted, counting down the reset stretch
// RUN    | free-running processor cycles
// HALTED | parked at phase 0, no enables
// STEP   | one processor cycle, then back to HALTED
module cpu_phase_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int PHASES   = 4,
    parameter int RST_HOLD = 8,
    parameter int PW       = $clog2(PHASES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          halt_req,
    input  logic          step_req,
    output logic          core_reset,
    output logic          imem_en,
    output logic          dmem_en,
    output logic          regfile_en,
    output logic          processor_en,
    output logic [PW-1:0] phase,
    output logic          halted,
    output logic [31:0]   cycle_count
);

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [31:0]   cycle_count_q, cycle_count_d;
    logic [PW-1:0] phase_q;
    logic          cnt_clear, cnt_run, cnt_wrap;
    logic          active;

    cpu_phase_counter #(
        .PHASES (PHASES),
        .PW     (PW)
    ) u_phase_counter (
        .clock   (clock),
        .reset   (reset),
        .clear_i (cnt_clear),
        .run_i   (cnt_run),
        .phase_o (phase_q),
        .wrap_o  (cnt_wrap)
    );

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cycle_count_d = cycle_count_q;
        cnt_clear     = 1'b1;
        cnt_run       = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = halt_req ? ST_HALTED : ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end
            ST_RUN: begin
                cnt_clear = 1'b0;
                cnt_run   = 1'b1;
                if (cnt_wrap) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                    if (halt_req) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_STEP: begin
                cnt_clear = 1'b0;
                cnt_run   = 1'b1;
                if (cnt_wrap) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                    state_d       = ST_HALTED;
                end
            end
            ST_HALTED: begin
                // Dropping halt resumes even if a step is requested in the same cycle.
                if (!halt_req) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= HW'(RST_HOLD - 1);
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign active       = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign core_reset   = (state_q == ST_HOLD);
    assign halted       = (state_q == ST_HALTED);
    assign imem_en      = active && (phase_q == PW'(PH_IMEM));
    assign dmem_en      = active && (phase_q == PW'(ph_dmem(PHASES)));
    assign regfile_en   = active && (phase_q == PW'(ph_commit(PHASES)));
    assign processor_en = regfile_en;
    assign phase        = phase_q;
    assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Scoreboard bench: driver feeds inputs and a processor-cycle level model,
// a monitor compares every cycle's outputs against the queued expectations.
module tb_cpu_phase_ctrl;

    localparam int PHASES   = 4;
    localparam int RST_HOLD = 8;
    localparam int PW       = $clog2(PHASES);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          halt_req = 1'b0;
    logic          step_req = 1'b0;
    logic          core_reset, imem_en, dmem_en, regfile_en, processor_en, halted;
    logic [PW-1:0] phase;
    logic [31:0]   cycle_count;

    cpu_phase_ctrl #(.PHASES(PHASES), .RST_HOLD(RST_HOLD)) dut (
        .clock        (clock),
        .reset        (reset),
        .halt_req     (halt_req),
        .step_req     (step_req),
        .core_reset   (core_reset),
        .imem_en      (imem_en),
        .dmem_en      (dmem_en),
        .regfile_en   (regfile_en),
        .processor_en (processor_en),
        .phase        (phase),
        .halted       (halted),
        .cycle_count  (cycle_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          core_reset;
        logic [3:0]    en;          // {imem, dmem, regfile, processor}
        logic [PW-1:0] phase;
        logic          halted;
        logic [31:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: processor-cycle view of the sequencer.
    bit          m_in_hold;
    int          m_hold_left;
    bit          m_halted;
    bit          m_stepping;
    int          m_pos;
    logic [31:0] m_cnt;

    function automatic bit m_running();
        return !m_in_hold && !m_halted;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        bit   act;
        act          = m_running();
        e.core_reset = m_in_hold;
        e.en[3]      = act && (m_pos == 0);
        e.en[2]      = act && (m_pos == PHASES / 2);
        e.en[1]      = act && (m_pos == PHASES - 1);
        e.en[0]      = act && (m_pos == PHASES - 1);
        e.phase      = PW'(m_pos);
        e.halted     = m_halted;
        e.cnt        = m_cnt;
        return e;
    endfunction

    task automatic model_step(input bit r, input bit h, input bit s);
        if (r) begin
            m_in_hold   = 1'b1;
            m_hold_left = RST_HOLD;
            m_halted    = 1'b0;
            m_stepping  = 1'b0;
            m_pos       = 0;
            m_cnt       = '0;
        end else if (m_in_hold) begin
            m_hold_left = m_hold_left - 1;
            if (m_hold_left == 0) begin
                m_in_hold = 1'b0;
                m_halted  = h;
            end
        end else if (m_halted) begin
            if (!h) begin
                m_halted = 1'b0;
            end else if (s) begin
                m_halted   = 1'b0;
                m_stepping = 1'b1;
            end
        end else if (m_pos == PHASES - 1) begin
            m_cnt = m_cnt + 32'd1;
            m_pos = 0;
            if (m_stepping) begin
                m_stepping = 1'b0;
                m_halted   = 1'b1;
            end else if (h) begin
                m_halted = 1'b1;
            end
        end else begin
            m_pos = m_pos + 1;
        end
    endtask

    task automatic drive(input bit r, input bit h, input bit s, input bit frc = 1'b0);
        @(negedge clock);
        reset    = r;
        halt_req = h;
        step_req = s;
        if (frc) begin
            force dut.cycle_count_q = 32'hFFFF_FFFF;
            m_cnt = 32'hFFFF_FFFF;
        end
        model_step(r, h, s);
        exp_q.push_back(model_out());
        if (frc) begin
            #1;
            release dut.cycle_count_q;
        end
    endtask

    task automatic run_until(input int pos, input int cnt, input bit h, input string name);
        int n;
        n = 0;
        while (!(m_running() && m_pos == pos && (cnt < 0 || m_cnt == 32'(cnt)))) begin
            if (n >= 400) begin
                checks++;
                failures++;
                $display("FAIL wait_%s: condition not reached within %0d cycles", name, n);
                break;
            end
            drive(1'b0, h, 1'b0);
            n++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("core_reset",   32'(core_reset),   32'(e.core_reset));
                check("imem_en",      32'(imem_en),      32'(e.en[3]));
                check("dmem_en",      32'(dmem_en),      32'(e.en[2]));
                check("regfile_en",   32'(regfile_en),   32'(e.en[1]));
                check("processor_en", 32'(processor_en), 32'(e.en[0]));
                check("phase",        32'(phase),        32'(e.phase));
                check("halted",       32'(halted),       32'(e.halted));
                check("cycle_count",  cycle_count,       e.cnt);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        bit h;
        int n;

        // Reset for 3 cycles, then run 10 processor cycles.
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        run_until(0, 10, 1'b0, "ten_cycles");
        repeat (5) drive(1'b0, 1'b0, 1'b0);

        // Halt requested at phase 1, then hold it well past the halt.
        run_until(1, -1, 1'b0, "phase1");
        repeat (30) drive(1'b0, 1'b1, 1'b0);

        // Single step with a second step_req landing during STEP.
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        repeat (8) drive(1'b0, 1'b1, 1'b0);

        // Resume and step in the same cycle: resume wins.
        drive(1'b0, 1'b0, 1'b1);
        repeat (12) drive(1'b0, 1'b0, 1'b0);

        // Reset mid-run at phase 2 with five completed cycles.
        repeat (2) drive(1'b1, 1'b0, 1'b0);
        run_until(2, 5, 1'b0, "cnt5_ph2");
        drive(1'b1, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0);

        // Counter wrap at 2^32-1.
        run_until(0, -1, 1'b0, "phase0");
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (10) drive(1'b0, 1'b0, 1'b0);

        // Randomized halt level, step pulses and occasional reset.
        h = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) h = ~h;
            drive(($urandom_range(0, 299) == 0), h, ($urandom_range(0, 4) == 0));
        end

        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clock);
            n++;
        end
        repeat (2) @(posedge clock);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
